// File: rtl/vortex_ahb_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : vortex_ahb_mem_bridge_if
// Purpose  : Bundles the Vortex line-memory handshake and the AHB-Lite
//            manager signals of vortex_ahb_mem_bridge.
//            master : the bridge side (drives AHB controls, line responses)
//            slave  : the environment (core requests, AHB subordinate)
// Revision : 1.0 - initial release
// ============================================================================
interface vortex_ahb_mem_bridge_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_WIDTH     = 512,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int TAG_WIDTH      = 56
);
  // Vortex line request
  logic                      mem_req_valid;
  logic                      mem_req_rw;
  logic [LINE_WIDTH/8-1:0]   mem_req_byteen;
  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr;
  logic [LINE_WIDTH-1:0]     mem_req_data;
  logic [TAG_WIDTH-1:0]      mem_req_tag;
  logic                      mem_req_ready;
  // Vortex line response
  logic                      mem_rsp_valid;
  logic [LINE_WIDTH-1:0]     mem_rsp_data;
  logic [TAG_WIDTH-1:0]      mem_rsp_tag;
  logic                      mem_rsp_ready;
  // AHB-Lite manager
  logic                      HSEL;
  logic                      HWRITE;
  logic                      HMASTLOCK;
  logic [1:0]                HTRANS;
  logic [2:0]                HSIZE;
  logic [2:0]                HBURST;
  logic [ADDR_WIDTH-1:0]     HADDR;
  logic [DATA_WIDTH-1:0]     HWDATA;
  logic [DATA_WIDTH/8-1:0]   HWSTRB;
  logic                      HREADY;
  logic                      HRESP;
  logic [DATA_WIDTH-1:0]     HRDATA;
  // Sticky error status
  logic                      bus_error;

  modport master (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
           HREADY, HRESP, HRDATA,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
           HSEL, HWRITE, HMASTLOCK, HTRANS, HSIZE, HBURST,
           HADDR, HWDATA, HWSTRB, bus_error
  );

  modport slave (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
           HREADY, HRESP, HRDATA,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
           HSEL, HWRITE, HMASTLOCK, HTRANS, HSIZE, HBURST,
           HADDR, HWDATA, HWSTRB, bus_error
  );
endinterface
`default_nettype wire

// File: rtl/vortex_ahb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : vortex_ahb_mem_bridge
// Purpose  : Serialises one 512-bit Vortex line request at a time into
//            32-bit AHB-Lite single transfers. Reads gather 16 words into a
//            tagged line response; writes issue only byte-enabled words.
// Revision : 1.0 - initial release
// ============================================================================
module vortex_ahb_mem_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_WIDTH     = 512,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int TAG_WIDTH      = 56
) (
  input  wire                     clk,
  input  wire                     reset,
  vortex_ahb_mem_bridge_if.master bus
);

  localparam int         c_words         = LINE_WIDTH / DATA_WIDTH;
  localparam int         c_idx_w         = $clog2(c_words);
  localparam int         c_strb_w        = DATA_WIDTH / 8;
  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                    state_q;
  logic                      rw_q;
  logic                      active_q;   // line has at least one beat to issue
  logic [LINE_WIDTH/8-1:0]   byteen_q;
  logic [LINE_WIDTH-1:0]     wdata_q;
  logic [LINE_WIDTH-1:0]     rdata_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [c_idx_w-1:0]        idx_q;
  logic [c_idx_w-1:0]        last_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic                      hsel_q;
  logic                      hwrite_q;
  logic [1:0]                htrans_q;
  logic [ADDR_WIDTH-1:0]     haddr_q;
  logic [DATA_WIDTH-1:0]     hwdata_q;
  logic [c_strb_w-1:0]       hwstrb_q;
  logic                      bus_error_q;

  logic [c_words-1:0]        w_req_nib;
  logic [c_words-1:0]        w_held_nib;
  logic [MEM_ADDR_WIDTH+5:0] w_req_line_byte;
  logic [ADDR_WIDTH-1:0]     w_req_base;
  logic [c_idx_w-1:0]        w_first_idx;
  logic [c_idx_w-1:0]        w_last_idx;
  logic                      w_req_any;
  logic [c_idx_w-1:0]        w_next_idx;
  logic                      w_found;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [c_idx_w-1:0]    idx
  );
    return base + ADDR_WIDTH'({idx, 2'b00});
  endfunction

  // Per-word "any byte enabled" flags for the incoming and the held request
  for (genvar gi = 0; gi < c_words; gi++) begin : g_nib
    assign w_req_nib[gi]  = |bus.mem_req_byteen[gi*c_strb_w +: c_strb_w];
    assign w_held_nib[gi] = |byteen_q[gi*c_strb_w +: c_strb_w];
  end

  // Line byte address; upper bits beyond the AHB address space are dropped
  assign w_req_line_byte = {bus.mem_req_addr, 6'b0};
  assign w_req_base      = ADDR_WIDTH'(w_req_line_byte);

  // First and last beat of the incoming request (reads always span the line)
  always_comb begin
    w_first_idx = '0;
    w_last_idx  = c_idx_w'(c_words - 1);
    w_req_any   = 1'b1;
    if (bus.mem_req_rw) begin
      w_req_any  = |w_req_nib;
      w_last_idx = '0;
      for (int i = c_words - 1; i >= 0; i--) begin
        if (w_req_nib[i]) w_first_idx = c_idx_w'(i);
      end
      for (int i = 0; i < c_words; i++) begin
        if (w_req_nib[i]) w_last_idx = c_idx_w'(i);
      end
    end
  end

  // Next beat after the current one: sequential for reads, next enabled word for writes
  always_comb begin
    w_next_idx = idx_q + 1'b1;
    w_found    = 1'b0;
    if (rw_q) begin
      w_next_idx = idx_q;
      for (int i = 0; i < c_words; i++) begin
        if (!w_found && w_held_nib[i] && (c_idx_w'(i) > idx_q)) begin
          w_next_idx = c_idx_w'(i);
          w_found    = 1'b1;
        end
      end
    end
  end

  // Line sequencer: request capture, beat stepping and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      active_q    <= 1'b0;
      byteen_q    <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      tag_q       <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      hsel_q      <= 1'b0;
      hwrite_q    <= 1'b0;
      htrans_q    <= c_htrans_idle;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      hwstrb_q    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.mem_req_valid && req_ready_q) begin
            rw_q        <= bus.mem_req_rw;
            byteen_q    <= bus.mem_req_byteen;
            wdata_q     <= bus.mem_req_data;
            tag_q       <= bus.mem_req_tag;
            base_q      <= w_req_base;
            idx_q       <= w_first_idx;
            last_q      <= w_last_idx;
            active_q    <= w_req_any;
            req_ready_q <= 1'b0;
            state_q     <= S_ADDR;
            // An all-zero write still spends one ADDR cycle, but silently
            if (w_req_any) begin
              htrans_q <= c_htrans_nonseq;
              hsel_q   <= 1'b1;
              hwrite_q <= bus.mem_req_rw;
              haddr_q  <= word_addr(w_req_base, w_first_idx);
            end
          end
        end

        S_ADDR: begin
          htrans_q <= c_htrans_idle;
          hsel_q   <= 1'b0;
          hwrite_q <= 1'b0;
          haddr_q  <= '0;
          if (active_q) begin
            state_q <= S_DATA;
            if (rw_q) begin
              hwdata_q <= wdata_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
              hwstrb_q <= byteen_q[idx_q*c_strb_w +: c_strb_w];
            end
          end else begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end
        end

        S_DATA: begin
          if (bus.HREADY) begin
            hwdata_q <= '0;
            hwstrb_q <= '0;
            if (bus.HRESP) bus_error_q <= 1'b1;
            // An errored read beat contributes zeros to the line
            if (!rw_q) begin
              rdata_q[idx_q*DATA_WIDTH +: DATA_WIDTH] <= bus.HRESP ? '0 : bus.HRDATA;
            end
            if (idx_q == last_q) begin
              if (rw_q) begin
                state_q     <= S_IDLE;
                req_ready_q <= 1'b1;
              end else begin
                state_q     <= S_RESP;
                rsp_valid_q <= 1'b1;
              end
            end else begin
              idx_q    <= w_next_idx;
              state_q  <= S_ADDR;
              htrans_q <= c_htrans_nonseq;
              hsel_q   <= 1'b1;
              hwrite_q <= rw_q;
              haddr_q  <= word_addr(base_q, w_next_idx);
            end
          end
        end

        S_RESP: begin
          if (bus.mem_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req_ready = req_ready_q;
  assign bus.mem_rsp_valid = rsp_valid_q;
  assign bus.mem_rsp_data  = rdata_q;
  assign bus.mem_rsp_tag   = tag_q;
  assign bus.HSEL          = hsel_q;
  assign bus.HWRITE        = hwrite_q;
  assign bus.HMASTLOCK     = 1'b0;
  assign bus.HTRANS        = htrans_q;
  assign bus.HSIZE         = 3'b010;
  assign bus.HBURST        = 3'b000;
  assign bus.HADDR         = haddr_q;
  assign bus.HWDATA        = hwdata_q;
  assign bus.HWSTRB        = hwstrb_q;
  assign bus.bus_error     = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_vortex_ahb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_vortex_ahb_mem_bridge
// Purpose  : Self-checking bench for vortex_ahb_mem_bridge. Directed line
//            transactions plus random ones against a transaction-level
//            reference (expected beat list, cycle arithmetic, line contents).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vortex_ahb_mem_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vortex_ahb_mem_bridge_if bus ();

  vortex_ahb_mem_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Current transaction description
  logic         t_rw;
  logic [25:0]  t_addr;
  logic [63:0]  t_byteen;
  logic [511:0] t_data;
  logic [55:0]  t_tag;
  logic [31:0]  t_rdata [16];
  int           t_wait  [16];
  logic         t_err   [16];
  int           t_rsp_delay;
  logic         model_bus_error;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 16; i++) begin
      t_rdata[i] = '0;
      t_wait[i]  = 0;
      t_err[i]   = 1'b0;
    end
    t_byteen    = '0;
    t_data      = '0;
    t_tag       = '0;
    t_rsp_delay = 0;
  endtask

  // Runs one line transaction, acting as AHB subordinate and response sink,
  // then compares everything seen against the expected transaction.
  task automatic do_line(input string name);
    int           exp_idx [$];
    int           exp_cyc [$];
    logic [31:0]  obs_addr[$];
    logic         obs_wr  [$];
    int           obs_cyc [$];
    logic [511:0] exp_line;
    logic [511:0] rsp_line;
    logic [55:0]  rsp_tag;
    logic [31:0]  base;
    int           tw, cyc, ready_cyc, rsp_cyc, wl, rsp_cnt, cur_w, exp_ready;
    bit           in_data, rsp_seen, unstable;

    base = {t_addr, 6'b0};
    tw   = 0;
    for (int i = 0; i < 16; i++) begin
      exp_line[32*i +: 32] = t_err[i] ? 32'h0 : t_rdata[i];
      if (!t_rw || (t_byteen[4*i +: 4] != 4'h0)) begin
        exp_cyc.push_back(2 * exp_idx.size() + 1 + tw);
        exp_idx.push_back(i);
        tw += t_wait[i];
        if (t_err[i]) model_bus_error = 1'b1;
      end
    end

    check_val({name, " req_ready"}, bus.mem_req_ready, 1'b1);
    bus.mem_req_valid  = 1'b1;
    bus.mem_req_rw     = t_rw;
    bus.mem_req_addr   = t_addr;
    bus.mem_req_byteen = t_byteen;
    bus.mem_req_data   = t_data;
    bus.mem_req_tag    = t_tag;
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0;

    cyc = 1; ready_cyc = -1; rsp_cyc = -1; wl = 0; cur_w = 0;
    rsp_cnt = t_rsp_delay; in_data = 0; rsp_seen = 0; unstable = 0;
    rsp_line = '0; rsp_tag = '0;
    while (cyc <= 200) begin
      // data phase of an outstanding transfer
      if (in_data) begin
        if (wl > 0) begin
          bus.HREADY = 1'b0;
          bus.HRESP  = 1'b0;
          wl--;
        end else begin
          bus.HREADY = 1'b1;
          bus.HRESP  = t_err[cur_w];
          bus.HRDATA = t_rdata[cur_w];
          in_data    = 0;
          if (t_rw) begin
            check_val($sformatf("%s hwdata[%0d]", name, cur_w), bus.HWDATA, t_data[32*cur_w +: 32]);
            check_val($sformatf("%s hwstrb[%0d]", name, cur_w), bus.HWSTRB, t_byteen[4*cur_w +: 4]);
          end
        end
      end else begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = $urandom;
      end
      // address phase
      if (bus.HTRANS == 2'b10) begin
        obs_addr.push_back(bus.HADDR);
        obs_wr.push_back(bus.HWRITE);
        obs_cyc.push_back(cyc);
        check_val({name, " addr_ctl"},
                  {bus.HSEL, bus.HSIZE, bus.HBURST, bus.HMASTLOCK, bus.HWSTRB, bus.HWDATA},
                  {1'b1, 3'b010, 3'b000, 1'b0, 4'h0, 32'h0});
        cur_w   = int'((bus.HADDR - base) >> 2) & 15;
        wl      = t_wait[cur_w];
        in_data = 1;
      end
      // line response sink
      if (bus.mem_rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1;
          rsp_cyc  = cyc;
          rsp_line = bus.mem_rsp_data;
          rsp_tag  = bus.mem_rsp_tag;
        end else if (bus.mem_rsp_data !== rsp_line || bus.mem_rsp_tag !== rsp_tag) begin
          unstable = 1;
        end
        if (rsp_cnt == 0) bus.mem_rsp_ready = 1'b1;
        else begin
          bus.mem_rsp_ready = 1'b0;
          rsp_cnt--;
        end
      end else begin
        bus.mem_rsp_ready = 1'b0;
      end
      if (bus.mem_req_ready) begin
        ready_cyc = cyc;
        break;
      end
      cyc++;
      @(posedge clk); #1;
    end
    bus.mem_rsp_ready = 1'b0;
    bus.HREADY        = 1'b1;
    bus.HRESP         = 1'b0;

    if (ready_cyc < 0) check_val({name, " timeout"}, 1'b0, 1'b1);
    check_val({name, " nbeats"}, obs_addr.size(), exp_idx.size());
    for (int k = 0; k < exp_idx.size() && k < obs_addr.size(); k++) begin
      check_val($sformatf("%s haddr[%0d]", name, k), obs_addr[k], base + 32'(4 * exp_idx[k]));
      check_val($sformatf("%s hwrite[%0d]", name, k), obs_wr[k], t_rw);
      check_val($sformatf("%s acyc[%0d]", name, k), obs_cyc[k], exp_cyc[k]);
    end
    if (t_rw) begin
      check_val({name, " no_rsp"}, rsp_seen, 1'b0);
      exp_ready = (exp_idx.size() == 0) ? 2 : 2 * exp_idx.size() + 1 + tw;
    end else begin
      check_val({name, " rsp_cyc"}, rsp_cyc, 33 + tw);
      check_val({name, " rsp_data"}, rsp_line, exp_line);
      check_val({name, " rsp_tag"}, rsp_tag, t_tag);
      check_val({name, " rsp_stable"}, unstable, 1'b0);
      exp_ready = 33 + tw + t_rsp_delay + 1;
    end
    check_val({name, " ready_cyc"}, ready_cyc, exp_ready);
    check_val({name, " bus_error"}, bus.bus_error, model_bus_error);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] tmp64;
    logic [31:0] rbase;
    int          bad;

    bus.mem_req_valid  = 1'b0;
    bus.mem_req_rw     = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_byteen = '0;
    bus.mem_req_data   = '0;
    bus.mem_req_tag    = '0;
    bus.mem_rsp_ready  = 1'b0;
    bus.HREADY         = 1'b1;
    bus.HRESP          = 1'b0;
    bus.HRDATA         = '0;
    model_bus_error    = 1'b0;
    clear_cfg();

    // Reset values
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_val("reset ctl",
              {bus.mem_req_ready, bus.mem_rsp_valid, bus.HTRANS, bus.HSEL, bus.HWRITE, bus.HMASTLOCK, bus.bus_error},
              {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    check_val("reset haddr", bus.HADDR, 32'h0);
    check_val("reset hw", {bus.HWDATA, bus.HWSTRB}, 36'h0);
    check_val("reset rsp_data", bus.mem_rsp_data, 512'h0);
    check_val("reset rsp_tag", bus.mem_rsp_tag, 56'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Read of the top line region, slave data 0x1000_0000+i
    clear_cfg();
    t_rw = 1'b0; t_addr = 26'h3C0_0000; t_tag = 56'hAB_CDEF_0123_4567;
    for (int i = 0; i < 16; i++) t_rdata[i] = 32'h1000_0000 + 32'(i);
    do_line("read_basic");

    // Full-line write
    clear_cfg();
    t_rw = 1'b1; t_addr = 26'h000_1234; t_byteen = '1;
    for (int i = 0; i < 16; i++) t_data[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
    do_line("write_full");

    // Sparse write: words 3 and 12 only
    clear_cfg();
    t_rw = 1'b1; t_addr = 26'h155_AAAA;
    t_byteen[15:12] = 4'b0011;
    t_byteen[51:48] = 4'b1000;
    for (int i = 0; i < 16; i++) t_data[32*i +: 32] = $urandom;
    do_line("write_sparse");

    // Write with nothing enabled
    clear_cfg();
    t_rw = 1'b1; t_addr = 26'h0AB_CDEF;
    for (int i = 0; i < 16; i++) t_data[32*i +: 32] = $urandom;
    do_line("write_empty");

    // Read with wait states on beat 5 and an error on beat 9
    clear_cfg();
    t_rw = 1'b0; t_addr = 26'h012_3456; t_tag = 56'h11_2233_4455_6677;
    for (int i = 0; i < 16; i++) t_rdata[i] = $urandom;
    t_wait[5] = 3; t_err[9] = 1'b1; t_rsp_delay = 2;
    do_line("read_wait_err");

    // Clean write afterwards: bus_error must remain set
    clear_cfg();
    t_rw = 1'b1; t_addr = 26'h000_0001; t_byteen[3:0] = 4'hF; t_data[31:0] = 32'hDEAD_BEEF;
    do_line("write_sticky");

    // Random lines
    for (int n = 0; n < 30; n++) begin
      clear_cfg();
      t_rw   = 1'($urandom_range(0, 1));
      t_addr = 26'($urandom);
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0:       t_byteen[4*i +: 4] = 4'h0;
          1:       t_byteen[4*i +: 4] = 4'hF;
          default: t_byteen[4*i +: 4] = 4'($urandom);
        endcase
        t_data[32*i +: 32] = $urandom;
        t_rdata[i]         = $urandom;
        if ($urandom_range(0, 9) < 2) t_wait[i] = int'($urandom_range(1, 3));
        t_err[i] = ($urandom_range(0, 19) == 0);
      end
      t_rsp_delay = int'($urandom_range(0, 3));
      tmp64 = {$urandom, $urandom};
      t_tag = tmp64[55:0];
      do_line($sformatf("rnd%0d", n));
    end

    // Reset during the data phase of beat 7 of a read
    clear_cfg();
    t_addr = 26'h155_5555;
    rbase  = {t_addr, 6'b0};
    check_val("rst req_ready", bus.mem_req_ready, 1'b1);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = t_addr;
    bus.mem_req_tag   = 56'h5A;
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0;
    for (int c = 1; c < 15; c++) begin
      @(posedge clk); #1;
    end
    check_val("rst beat7 addr", {bus.HTRANS, bus.HADDR}, {2'b10, rbase + 32'd28});
    @(posedge clk); #1;
    check_val("rst bus_error before", bus.bus_error, model_bus_error);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("rst state",
              {bus.mem_req_ready, bus.mem_rsp_valid, bus.HTRANS, bus.HSEL, bus.bus_error},
              {1'b1, 1'b0, 2'b00, 1'b0, 1'b0});
    reset = 1'b0;
    model_bus_error = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.mem_rsp_valid || bus.HTRANS != 2'b00 || !bus.mem_req_ready) bad++;
    end
    check_val("rst quiet", bad, 0);

    // Normal operation after the abandoned line
    clear_cfg();
    t_rw = 1'b0; t_addr = 26'h3FF_FFFF; t_tag = 56'h77;
    for (int i = 0; i < 16; i++) t_rdata[i] = $urandom;
    t_rsp_delay = 1;
    do_line("read_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vortex_ahb_mem_bridge.md
# vortex_ahb_mem_bridge

Converts Vortex's 512-bit cache-line memory interface (mem_req_*/mem_rsp_*) into a sequence of 32-bit AHB-Lite single transfers on the wrapper's AHB manager port. It sits directly downstream of the Vortex core. It serves one line request at a time: writes become up to 16 word writes, and reads become 16 word reads reassembled into a single tagged line response.

## Interface
- ADDR_WIDTH, 32: AHB address width.
- DATA_WIDTH, 32: AHB data width; only 32 is supported.
- LINE_WIDTH, 512: Vortex line width (VX_MEM_DATA_WIDTH).
- MEM_ADDR_WIDTH, 26: Vortex line-address width (VX_MEM_ADDR_WIDTH).
- TAG_WIDTH, 56: Vortex tag width (VX_MEM_TAG_WIDTH).
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- mem_req_valid  in  1  request valid.
- mem_req_rw  in  1  1 = write, 0 = read.
- mem_req_byteen  in  LINE_WIDTH/8  byte enables (writes only).
- mem_req_addr  in  MEM_ADDR_WIDTH  line address.
- mem_req_data  in  LINE_WIDTH  write line.
- mem_req_tag  in  TAG_WIDTH  request tag.
- mem_req_ready  out  1  request accepted.
- mem_rsp_valid  out  1  read response valid.
- mem_rsp_data  out  LINE_WIDTH  read line.
- mem_rsp_tag  out  TAG_WIDTH  tag of the read.
- mem_rsp_ready  in  1  response consumed.
- HSEL, HWRITE, HMASTLOCK  out  1 each  AHB manager controls.
- HTRANS  out  2  AHB transfer type.
- HSIZE, HBURST  out  3 each  AHB size and burst type.
- HADDR, HWDATA  out  32 each  AHB address and write data.
- HWSTRB  out  4  AHB write strobes.
- HREADY, HRESP  in  1 each  AHB bus inputs.
- HRDATA  in  32  AHB read data.
- bus_error  out  1  sticky error flag; set when any beat receives HRESP=1.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- Outputs in IDLE:
  - mem_req_ready = (state==IDLE).
  - On mem_req_valid && mem_req_ready, the block latches rw, byteen, addr, data and tag.
  - Base byte address = {mem_req_addr, 6'b0}, truncated to 32 bits.
- Word i (0..15) mapping:
  - line bits [32i+31:32i]
  - byteen bits [4i+3:4i]
  - HADDR = base + 4i
  - Order is little-endian.
- Beat selection:
  - Reads: all 16 words, i = 0..15 in order.
  - Writes: only words with a nonzero byteen nibble, in ascending order.
  - A write with all-zero byteen returns directly to IDLE with no AHB activity.
- ADDR state (one cycle):
  - HTRANS=NONSEQ (2'b10), HSEL=1, HADDR per current word, HWRITE=rw.
  - HSIZE=3'b010, HBURST=3'b000.
  - Next state: DATA.
- DATA state:
  - HTRANS=IDLE, HSEL=0.
  - Writes: HWDATA = word i, HWSTRB = its nibble.
  - The state holds while HREADY=0.
  - On HREADY=1 the beat completes:
    - Reads store HRDATA into word i. If HRESP=1, the block stores 0 and sets bus_error.
    - Writes with HRESP=1 also set bus_error.
  - Next state: ADDR for the next selected word. After the last beat: RESP for reads, IDLE for writes.
- RESP state:
  - mem_rsp_valid=1; mem_rsp_data and mem_rsp_tag are held stable.
  - On mem_rsp_ready=1 the next state is IDLE.
- Writes produce no mem_rsp.
- HMASTLOCK=0 always.
- HWDATA=0 and HWSTRB=0 outside DATA.
- bus_error is cleared only by reset.

## Timing
- Reset: when reset is asserted at an edge, state becomes IDLE and bus_error=0. After reset: mem_req_ready=1, mem_rsp_valid=0, HTRANS=IDLE, HSEL=0, HWRITE=0, HADDR=0, mem_rsp_data=0, mem_rsp_tag=0.
- Reset mid-operation:
  - The line is abandoned and no response is produced.
  - HTRANS=IDLE from the next cycle.
- Read latency (handshake at edge 0, zero wait states):
  - Beat k address phase in cycle 2k+1; data phase in cycle 2k+2.
  - mem_rsp_valid rises in cycle 33.
  - mem_req_ready returns the cycle after the rsp handshake.
- Write latency:
  - n enabled words take 2n cycles.
  - mem_req_ready is 1 again in cycle 2n+1.
- Wait states: each HREADY=0 cycle in DATA adds exactly one cycle.
- Handshake rules:
  - No new request is accepted while busy.
  - mem_rsp_valid, once high, stays high until mem_rsp_ready.
- Beat counter: a 4-bit counter. The last beat is detected as index 15 for reads, or as the highest enabled nibble for writes; the counter never wraps.

## Test plan
- Read at addr 26'h3C0_0000 (base 0xF000_0000), slave returns 0x1000_0000+i, zero waits:
  - HADDR sequence 0xF000_0000..0xF000_003C.
  - mem_rsp_valid in cycle 33.
  - Word i = 0x1000_0000+i; tag echoed.
- Full write, data word i = 0xA5A5_0000+i, byteen all ones:
  - 16 writes with HWSTRB=4'hF.
  - mem_req_ready high again at cycle 33.
  - No mem_rsp_valid.
- Sparse write, byteen nibbles only at words 3 (4'b0011) and 12 (4'b1000):
  - Exactly two transfers, at base+0xC and base+0x30, with those strobes.
  - Ready at cycle 5.
- All-zero byteen write: no HTRANS≠IDLE; mem_req_ready back 2 cycles after accept.
- Read with 3 HREADY=0 cycles on beat 5 and HRESP=1 on beat 9:
  - Response in cycle 36.
  - Word 9 = 0; bus_error=1 and sticky.
- Reset asserted during beat 7 of a read, mem_rsp_ready held 0 throughout:
  - Next cycle: IDLE, mem_req_ready=1, bus_error=0.
  - No mem_rsp_valid.
